adxl345_spi_responder: RTL and testbench
========================================

# adxl345_spi_responder

Synthesizable SPI slave emulating the ADXL345 register interface (mode 3, 8-bit command plus data bytes) behind an oversampled, synchronized SPI pin interface. It is the responder end of the accelerometer SPI link: it lets the accelerometer master be exercised on-board or in simulation without the physical part. Acceleration samples come in through a parallel port and are exposed at DATAX0..DATAZ1. Register writes are reported through a strobe.

## Interface

Parameters:
- DEVICE_ID, 8'hE5, value returned at register 0x00.
- SYNC_STAGES, 2, synchronizer depth on sck, cs and mosi (minimum 2).

Ports:
- clk  input  1  system clock; must be at least 8x the sck frequency.
- reset  input  1  asynchronous, active-low reset.
- sck  input  1  SPI clock, CPOL=1.
- cs  input  1  chip select, active-low.
- mosi  input  1  master-out data.
- miso  output  1  slave-out data; 0 whenever cs is high.
- sample_valid  input  1  single-cycle strobe for a new sample.
- sample_data  input  48  {Z1,Z0,Y1,Y0,X1,X0}; X0 is in [7:0].
- write_strobe  output  1  one-cycle pulse per accepted register write.
- write_addr  output  6  address of the last accepted write.
- write_data  output  8  data of the last accepted write.
- measure  output  1  POWER_CTL (0x2D) bit 3.
- data_ready  output  1  INT_SOURCE (0x30) bit 7.

## Operation

- **Input path.** sck, cs and mosi each pass through SYNC_STAGES flops, then a 1-flop edge detector. All protocol actions use the detected sck rise/fall while synchronized cs is low.
- **Mode 3.** mosi is sampled on each sck rise. miso changes on each sck fall.
- **Command byte.** The first 8 rises of a transaction form the command: bit7 R/W (1 = read), bit6 MB, bits[5:0] start address. miso is 0 throughout the command byte.
- **Read.**
  - On the first fall after the 8th rise, the shift register loads the value at the current address and miso presents its bit7.
  - Each later fall shifts the next bit out, MSB first.
  - Each following byte loads on the fall after its preceding 8th rise.
- **Write.** On the 8th rise of each data byte, the assembled byte is written to the current address if that address is writable. In the same cycle write_strobe pulses and write_addr/write_data update.
- **Address advance.** After each data byte, the address increments if MB=1, wrapping 0x3F to 0x00. If MB=0 the address stays unchanged, so repeated bytes hit the same register.
- **Register map (64 x 8).**
  - Read-only: 0x00 (returns DEVICE_ID), 0x30, 0x32..0x37.
  - Reserved: 0x01..0x1C read 0x00.
  - Writes to read-only or reserved addresses are dropped, with no strobe.
  - All other addresses are read/write.
- **Reset values.** 0x2C = 0x0A, 0x30 = 0x02; all other storage is 0x00.
- **Samples.**
  - sample_valid while cs is high: sample_data is written to 0x32..0x37 and 0x30 bit7 is set.
  - sample_valid while cs is low: the sample is held in a one-deep pending buffer; a newer sample overwrites it. The pending sample is applied in the cycle synchronized cs rises.
- **DATA_READY clear.** If any byte at 0x32..0x37 was read during a transaction, 0x30 bit7 clears at the cs rise. If a pending sample is applied in that same cycle, bit7 stays set (set wins).
- **Transaction abort.** A cs rise mid-byte discards the partial byte: no write, no strobe. The bit counter and state return to idle.
- **Mid-transaction reset.** Asserting reset at any point clears all state, the registers and the pending sample immediately.

## Timing

- **Reset values of outputs:** miso 0, write_strobe 0, write_addr 0, write_data 0, measure 0, data_ready 0.
- **Pin-to-action latency:** an sck edge at the pin is acted on SYNC_STAGES+1 clk cycles later.
- **miso timing:** miso updates 1 cycle after the detected fall. This must settle well before the next sck rise, which the 8x clock ratio guarantees.
- **Write latency:** write_strobe asserts 1 cycle after the detected 8th rise of a data byte. measure reflects the new value in the same cycle as the strobe.
- **Sample latency:** a sample accepted while idle is readable and data_ready is high 1 cycle after sample_valid.
- **Control FSM:** IDLE → CMD (cs fall) → DATA (8th rise) → DATA repeating per byte; any state → IDLE on cs rise.
- **cs setup:** cs fall to first sck fall is at least 2 sck half-periods.

## Test plan

- Reset, then transaction cmd 0x80 plus one dummy byte → miso shifts out 0xE5; measure=0, data_ready=0.
- Write cmd 0x2D, data 0x08 → one write_strobe with write_addr 0x2D, write_data 0x08; measure=1. Then read cmd 0xAD → 0x08.
- With cs high, pulse sample_valid with sample_data 48'h665544332211 → data_ready=1. Then multi-byte read cmd 0xF2 with 6 data bytes → 11 22 33 44 55 66, and data_ready=0 after cs rises.
- During the read above, pulse sample_valid with 48'hFFEEDDCCBBAA → the in-flight bytes remain the old values. After cs rises, a re-read returns AA BB CC DD EE FF and data_ready=1.
- Write cmd 0x31, then raise cs after 5 data bits → 0x31 stays 0x00 and there is no strobe. The next full write of 0x31 = 0x0B succeeds.
- Write cmd 0x7F (MB, address 0x3F), data 0xAA, 0xBB → 0x3F = 0xAA with exactly one strobe. The second byte wraps to 0x00, which is read-only, so it is dropped; a subsequent read of 0x00 still returns 0xE5.

Source files
------------

// File: rtl/adxl345_spi_responder.sv
// ADXL345 register-map SPI responder (mode 3) used in place of the physical accelerometer.
// SPI pins are oversampled by clk through synchronizers and single-flop edge detectors.
module adxl345_spi_responder #(
    parameter logic [7:0] DEVICE_ID   = 8'hE5,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sck,
    input  logic        cs,
    input  logic        mosi,
    output logic        miso,
    input  logic        sample_valid,
    input  logic [47:0] sample_data,
    output logic        write_strobe,
    output logic [5:0]  write_addr,
    output logic [7:0]  write_data,
    output logic        measure,
    output logic        data_ready
);
    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sck_prev_q, cs_prev_q;
    logic                   sck_s, cs_s, mosi_s;
    logic                   sck_rise, sck_fall, cs_rise, cs_fall;
    logic [2:0]             bit_cnt_q;
    logic [7:0]             shift_in_q, byte_in;
    logic [6:0]             shift_out_q;
    logic                   miso_q, byte_done_q, rw_q, mb_q, rd_data_q;
    logic [5:0]             addr_q;
    logic [7:0]             regs_q [64];
    logic [47:0]            pend_q, sample_src;
    logic                   pend_vld_q, sample_load;
    logic                   write_strobe_q;
    logic [5:0]             write_addr_q;
    logic [7:0]             write_data_q, rdata;

    function automatic logic writable(input logic [5:0] a);
        return !(a <= 6'h1C || a == 6'h30 || (a >= 6'h32 && a <= 6'h37));
    endfunction

    function automatic logic is_sample_reg(input logic [5:0] a);
        return a >= 6'h32 && a <= 6'h37;
    endfunction

    // sck and cs reset to their idle-high level so release of reset creates no edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sck_sync_q  <= '1;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b1;
            cs_prev_q   <= 1'b1;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sck_prev_q  <= sck_s;
            cs_prev_q   <= cs_s;
        end
    end

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign cs_rise  = cs_s & ~cs_prev_q;
    assign cs_fall  = ~cs_s & cs_prev_q;
    assign byte_in  = {shift_in_q[6:0], mosi_s};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (cs_s) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (cs_fall) state_d = CMD;
                CMD:     if (sck_rise && bit_cnt_q == 3'd7) state_d = DATA;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        rdata = regs_q[addr_q];
        if (addr_q == 6'h00)      rdata = DEVICE_ID;
        else if (addr_q <= 6'h1C) rdata = 8'h00;
    end

    // A live sample strobe is newer than anything pending, so it takes precedence
    assign sample_load = (sample_valid && cs_s) || (cs_rise && pend_vld_q);
    assign sample_src  = (sample_valid && cs_s) ? sample_data : pend_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt_q      <= '0;
            shift_in_q     <= '0;
            shift_out_q    <= '0;
            miso_q         <= 1'b0;
            byte_done_q    <= 1'b0;
            rw_q           <= 1'b0;
            mb_q           <= 1'b0;
            addr_q         <= '0;
            rd_data_q      <= 1'b0;
            pend_q         <= '0;
            pend_vld_q     <= 1'b0;
            write_strobe_q <= 1'b0;
            write_addr_q   <= '0;
            write_data_q   <= '0;
            regs_q         <= '{default: 8'h00};
            regs_q[6'h2C]  <= 8'h0A;
            regs_q[6'h30]  <= 8'h02;
        end else begin
            write_strobe_q <= 1'b0;
            if (cs_s) begin
                bit_cnt_q   <= '0;
                byte_done_q <= 1'b0;
                miso_q      <= 1'b0;
            end else begin
                if (sck_rise) begin
                    shift_in_q <= byte_in;
                    bit_cnt_q  <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        byte_done_q <= 1'b1;
                        if (state_q == CMD) begin
                            rw_q   <= byte_in[7];
                            mb_q   <= byte_in[6];
                            addr_q <= byte_in[5:0];
                        end else if (state_q == DATA) begin
                            if (!rw_q && writable(addr_q)) begin
                                regs_q[addr_q] <= byte_in;
                                write_strobe_q <= 1'b1;
                                write_addr_q   <= addr_q;
                                write_data_q   <= byte_in;
                            end
                            if (mb_q) addr_q <= addr_q + 6'd1;
                        end
                    end
                end
                // The first fall after a completed byte loads the next read byte
                if (sck_fall && state_q == DATA && rw_q) begin
                    if (byte_done_q) begin
                        byte_done_q <= 1'b0;
                        shift_out_q <= rdata[6:0];
                        miso_q      <= rdata[7];
                        if (is_sample_reg(addr_q)) rd_data_q <= 1'b1;
                    end else begin
                        shift_out_q <= {shift_out_q[5:0], 1'b0};
                        miso_q      <= shift_out_q[6];
                    end
                end
            end

            if (sample_load) begin
                regs_q[6'h32]    <= sample_src[7:0];
                regs_q[6'h33]    <= sample_src[15:8];
                regs_q[6'h34]    <= sample_src[23:16];
                regs_q[6'h35]    <= sample_src[31:24];
                regs_q[6'h36]    <= sample_src[39:32];
                regs_q[6'h37]    <= sample_src[47:40];
                regs_q[6'h30][7] <= 1'b1;
            end else if (cs_rise && rd_data_q) begin
                regs_q[6'h30][7] <= 1'b0;
            end
            if (cs_rise) rd_data_q <= 1'b0;

            if (sample_valid && !cs_s) begin
                pend_q     <= sample_data;
                pend_vld_q <= 1'b1;
            end else if (cs_rise) begin
                pend_vld_q <= 1'b0;
            end
        end
    end

    assign miso         = miso_q & ~cs;
    assign write_strobe = write_strobe_q;
    assign write_addr   = write_addr_q;
    assign write_data   = write_data_q;
    assign measure      = regs_q[6'h2D][3];
    assign data_ready   = regs_q[6'h30][7];
endmodule

// File: tb/tb_adxl345_spi_responder.sv
// Bench for adxl345_spi_responder: transaction-level register-map model plus directed SPI traffic.
module tb_adxl345_spi_responder;
    localparam int H = 8;  // clk cycles per sck half-period

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sck = 1'b1;
    logic        cs = 1'b1;
    logic        mosi = 1'b0;
    logic        sample_valid = 1'b0;
    logic [47:0] sample_data = '0;
    logic        miso, write_strobe, measure, data_ready;
    logic [5:0]  write_addr;
    logic [7:0]  write_data;

    always #5 clk = ~clk;

    adxl345_spi_responder #(.DEVICE_ID(8'hE5), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .sck(sck), .cs(cs), .mosi(mosi), .miso(miso),
        .sample_valid(sample_valid), .sample_data(sample_data),
        .write_strobe(write_strobe), .write_addr(write_addr), .write_data(write_data),
        .measure(measure), .data_ready(data_ready)
    );

    int          n_assert = 0;
    int          n_fail = 0;
    int          strobe_cnt = 0;
    bit          quiet = 1'b0;
    logic [7:0]  m_regs [64];
    logic [47:0] m_pend;
    bit          m_pend_vld;
    bit          m_rd;
    logic [13:0] exp_wr_q[$];
    logic [7:0]  rx_q[$];
    logic [7:0]  exp_rx_q[$];
    logic [13:0] e_wr;
    logic [7:0]  tx_buf [8];
    logic [7:0]  last_rx [8];
    bit          mid_sample_en = 1'b0;
    logic [47:0] mid_sample_val = '0;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] m_read(input logic [5:0] a);
        if (a == 6'h00) return 8'hE5;
        if (a <= 6'h1C) return 8'h00;
        return m_regs[a];
    endfunction

    function automatic bit m_writable(input logic [5:0] a);
        return !(a <= 6'h1C || a == 6'h30 || (a >= 6'h32 && a <= 6'h37));
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 64; i++) m_regs[6'(i)] = 8'h00;
        m_regs[6'h2C] = 8'h0A;
        m_regs[6'h30] = 8'h02;
        m_pend_vld = 1'b0;
        m_rd = 1'b0;
    endtask

    task automatic m_apply(input logic [47:0] d);
        for (int i = 0; i < 6; i++) m_regs[6'(50 + i)] = d[8*i +: 8];
        m_regs[6'h30][7] = 1'b1;
    endtask

    task automatic pulse_sample(input logic [47:0] d);
        @(negedge clk);
        sample_valid = 1'b1;
        sample_data  = d;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic idle_sample(input logic [47:0] d);
        quiet = 1'b0;
        pulse_sample(d);
        m_apply(d);
        repeat (3) @(negedge clk);
        quiet = 1'b1;
    endtask

    // Master side of mode 3: drive mosi on the fall, sample miso just before the rise
    task automatic send_byte(input logic [7:0] b, input int bits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < bits; i++) begin
            @(negedge clk);
            sck  = 1'b0;
            mosi = b[3'(7 - i)];
            repeat (H) @(negedge clk);
            rx  = {rx[6:0], miso};
            sck = 1'b1;
            repeat (H - 1) @(negedge clk);
        end
    endtask

    task automatic xact(input logic [7:0] cmd, input int nbytes, input int extra_bits);
        logic [5:0] a;
        logic [7:0] rx;
        logic [7:0] exp_b;
        int         nb;
        a  = cmd[5:0];
        nb = nbytes + ((extra_bits > 0) ? 1 : 0);
        quiet = 1'b0;
        @(negedge clk);
        cs = 1'b0;
        repeat (2 * H) @(negedge clk);
        send_byte(cmd, 8, rx);
        exp_rx_q.push_back(8'h00);
        rx_q.push_back(rx);
        for (int k = 0; k < nb; k++) begin
            if (mid_sample_en && k == 2) begin
                pulse_sample(mid_sample_val);
                m_pend     = mid_sample_val;
                m_pend_vld = 1'b1;
            end
            exp_b = 8'h00;
            if (cmd[7]) begin
                exp_b = m_read(a);
                if (a >= 6'h32 && a <= 6'h37) m_rd = 1'b1;
            end else if (k < nbytes && m_writable(a)) begin
                m_regs[a] = tx_buf[3'(k)];
                exp_wr_q.push_back({a, tx_buf[3'(k)]});
            end
            send_byte(tx_buf[3'(k)], (k < nbytes) ? 8 : extra_bits, rx);
            if (k < nbytes) begin
                if (cmd[7]) begin
                    exp_rx_q.push_back(exp_b);
                    rx_q.push_back(rx);
                    last_rx[3'(k)] = rx;
                end
                if (cmd[6]) a = a + 6'd1;
            end
        end
        repeat (H) @(negedge clk);
        cs = 1'b1;
        if (m_rd) m_regs[6'h30][7] = 1'b0;
        if (m_pend_vld) begin
            m_apply(m_pend);
            m_pend_vld = 1'b0;
        end
        m_rd = 1'b0;
        repeat (10) @(negedge clk);
        quiet = 1'b1;
    endtask

    // Single compare process: strobes, received miso bytes, and steady-state outputs
    always @(negedge clk) begin
        if (reset) begin
            if (write_strobe) begin
                strobe_cnt++;
                if (exp_wr_q.size() == 0) begin
                    n_assert++;
                    n_fail++;
                    $display("FAIL write_strobe: unexpected strobe addr %0h data %0h, required no strobe",
                             write_addr, write_data);
                end else begin
                    e_wr = exp_wr_q.pop_front();
                    check("write_addr_data", 48'({write_addr, write_data}), 48'(e_wr));
                end
            end
            while (rx_q.size() > 0 && exp_rx_q.size() > 0)
                check("miso_byte", 48'(rx_q.pop_front()), 48'(exp_rx_q.pop_front()));
            if (quiet) begin
                check("measure", 48'(measure), 48'(m_regs[6'h2D][3]));
                check("data_ready", 48'(data_ready), 48'(m_regs[6'h30][7]));
                check("miso_idle", 48'(miso), 48'(0));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not complete, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        m_reset();
        repeat (3) @(negedge clk);
        check("rst_miso", 48'(miso), 48'(0));
        check("rst_write_strobe", 48'(write_strobe), 48'(0));
        check("rst_write_addr", 48'(write_addr), 48'(0));
        check("rst_write_data", 48'(write_data), 48'(0));
        check("rst_measure", 48'(measure), 48'(0));
        check("rst_data_ready", 48'(data_ready), 48'(0));
        reset = 1'b1;
        repeat (4) @(negedge clk);
        quiet = 1'b1;

        // Device ID read
        tx_buf[0] = 8'h00;
        xact(8'h80, 1, 0);
        check("devid", 48'(last_rx[0]), 48'hE5);
        check("measure_init", 48'(measure), 48'(0));
        check("data_ready_init", 48'(data_ready), 48'(0));

        // POWER_CTL write and readback
        tx_buf[0] = 8'h08;
        xact(8'h2D, 1, 0);
        check("strobes_after_powerctl", 48'(strobe_cnt), 48'(1));
        check("measure_set", 48'(measure), 48'(1));
        check("model_measure", 48'(m_regs[6'h2D]), 48'h08);
        xact(8'hAD, 1, 0);
        check("powerctl_readback", 48'(last_rx[0]), 48'h08);

        // Idle sample, then burst read with a sample arriving mid-transaction
        idle_sample(48'h665544332211);
        check("data_ready_after_sample", 48'(data_ready), 48'(1));
        mid_sample_en  = 1'b1;
        mid_sample_val = 48'hFFEEDDCCBBAA;
        xact(8'hF2, 6, 0);
        mid_sample_en  = 1'b0;
        for (int k = 0; k < 6; k++)
            check("burst_old", 48'(last_rx[3'(k)]), 48'(8'h11 * (k + 1)));
        check("data_ready_set_wins", 48'(data_ready), 48'(1));
        xact(8'hF2, 6, 0);
        for (int k = 0; k < 6; k++)
            check("burst_new", 48'(last_rx[3'(k)]), 48'(8'hAA + 8'h11 * k));
        check("data_ready_cleared", 48'(data_ready), 48'(0));

        // Aborted write, then a full write to the same register
        tx_buf[0] = 8'hFF;
        xact(8'h31, 0, 5);
        check("strobes_after_abort", 48'(strobe_cnt), 48'(1));
        xact(8'hB1, 1, 0);
        check("abort_reg_unchanged", 48'(last_rx[0]), 48'h00);
        tx_buf[0] = 8'h0B;
        xact(8'h31, 1, 0);
        xact(8'hB1, 1, 0);
        check("datafmt_written", 48'(last_rx[0]), 48'h0B);
        check("strobes_after_datafmt", 48'(strobe_cnt), 48'(2));

        // Multi-byte write wrapping from 0x3F into read-only 0x00
        tx_buf[0] = 8'hAA;
        tx_buf[1] = 8'hBB;
        xact(8'h7F, 2, 0);
        check("strobes_after_wrap", 48'(strobe_cnt), 48'(3));
        xact(8'hBF, 1, 0);
        check("reg3f", 48'(last_rx[0]), 48'hAA);
        xact(8'h80, 1, 0);
        check("devid_after_wrap", 48'(last_rx[0]), 48'hE5);

        // MB=0 repeated writes land on one register
        tx_buf[0] = 8'h12;
        tx_buf[1] = 8'h34;
        xact(8'h38, 2, 0);
        check("strobes_after_nomb", 48'(strobe_cnt), 48'(5));
        xact(8'hB8, 1, 0);
        check("nomb_last_wins", 48'(last_rx[0]), 48'h34);

        repeat (4) @(negedge clk);
        check("pending_strobes", 48'(exp_wr_q.size()), 48'(0));
        check("pending_rx", 48'(exp_rx_q.size()), 48'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
